vga_scaled_timing_gen: RTL and testbench

- Parametrised raster timing generator and integer-scale window addressing for the frame-buffer video output path.
- Generalises the fixed 1080p / 4x NES display path: every timing field, source size, scale factor, sync polarity and read latency is a parameter.
- Produces the scaled-window read address into the external screen buffer/palette and aligns the returned RGB with sync and data-enable.
- Adds border colour input, frame/line strobes and edge-detected resync to the emulated PPU frame.

---
 rtl/vga_scaled_timing_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_vga_scaled_timing_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaled_timing_gen.sv
// Raster timing generator with centred integer-scale window addressing.
// Counter position (h,v) drives a stage-0 register whose rd_en/rd_row/rd_col
// go to the external buffer; sync/de/strobes are delayed RD_LAT stages so they
// line up with the returned pixel in the registered output stage.
module vga_scaled_timing_gen #(
    parameter int H_ACTIVE    = 1920,
    parameter int H_FP        = 88,
    parameter int H_SYNC      = 44,
    parameter int H_BP        = 148,
    parameter int V_ACTIVE    = 1080,
    parameter int V_FP        = 4,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 36,
    parameter int HS_POL      = 1,
    parameter int VS_POL      = 1,
    parameter int SRC_W       = 256,
    parameter int SRC_H       = 240,
    parameter int SCALE       = 4,
    parameter int RD_LAT      = 1,
    parameter int RESYNC_LINE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_sync,
    input  logic [11:0]                border_rgb,
    input  logic [11:0]                pix_rgb,
    output logic                       rd_en,
    output logic [$clog2(SRC_H)-1:0]   rd_row,
    output logic [$clog2(SRC_W)-1:0]   rd_col,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       de,
    output logic [11:0]                rgb,
    output logic                       line_start,
    output logic                       frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int RW    = $clog2(SRC_H);
    localparam int CW    = $clog2(SRC_W);
    localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int X0_I  = (H_ACTIVE - SRC_W * SCALE) / 2;
    localparam int Y0_I  = (V_ACTIVE - SRC_H * SCALE) / 2;
    localparam int RS_IN  = (RESYNC_LINE >= Y0_I) && (RESYNC_LINE < Y0_I + SRC_H * SCALE);
    localparam int RS_OFF = (RS_IN != 0) ? (RESYNC_LINE - Y0_I) : 0;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] X_LO   = HW'(X0_I);
    localparam logic [HW-1:0] X_HI   = HW'(X0_I + SRC_W * SCALE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] Y_LO   = VW'(Y0_I);
    localparam logic [VW-1:0] Y_HI   = VW'(Y0_I + SRC_H * SCALE);
    localparam logic [VW-1:0] V_RS   = VW'(RESYNC_LINE);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
    localparam logic [SW-1:0] RS_VSUB  = SW'(RS_OFF % SCALE);
    localparam logic [RW-1:0] RS_ROW   = RW'(RS_OFF / SCALE);
    localparam logic          HS_ON    = 1'(HS_POL);
    localparam logic          VS_ON    = 1'(VS_POL);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic win;
        logic ls;
        logic fs;
    } ctl_t;

    logic          r_run;
    logic          r_fs_prev;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [SW-1:0] r_hsub;
    logic [SW-1:0] r_vsub;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    ctl_t          r_ctl [0:RD_LAT];

    logic          w_fs_edge;
    logic          w_line_wrap;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic          w_hwin_nxt;
    logic          w_vwin_nxt;
    logic [SW-1:0] w_hsub_nxt;
    logic [SW-1:0] w_vsub_nxt;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;
    ctl_t          w_ctl0;

    // Next raster position; resync overrides any line/frame wrap.
    always_comb begin
        w_fs_edge   = frame_sync & ~r_fs_prev;
        w_line_wrap = (r_h == H_LAST);
        w_h_nxt     = w_line_wrap ? '0 : r_h + HW'(1);
        w_v_nxt     = r_v;
        if (w_line_wrap) begin
            w_v_nxt = (r_v == V_LAST) ? '0 : r_v + VW'(1);
        end
        if (!r_run) begin
            w_h_nxt = '0;
            w_v_nxt = '0;
        end else if (w_fs_edge) begin
            w_h_nxt = '0;
            w_v_nxt = V_RS;
        end
    end

    // Source address for the next position: counters are tied to the position
    // they describe, so they restart at window entry instead of on leaving it.
    always_comb begin
        w_hwin_nxt = (w_h_nxt >= X_LO) && (w_h_nxt < X_HI);
        w_vwin_nxt = (w_v_nxt >= Y_LO) && (w_v_nxt < Y_HI);
        w_hsub_nxt = '0;
        w_col_nxt  = '0;
        if (w_hwin_nxt && (w_h_nxt != X_LO)) begin
            w_col_nxt = r_col;
            if (r_hsub == SUB_LAST) begin
                w_col_nxt = r_col + CW'(1);
            end else begin
                w_hsub_nxt = r_hsub + SW'(1);
            end
        end
        w_vsub_nxt = r_vsub;
        w_row_nxt  = r_row;
        if (!r_run) begin
            w_vsub_nxt = '0;
            w_row_nxt  = '0;
        end else if (w_fs_edge) begin
            w_vsub_nxt = RS_VSUB;
            w_row_nxt  = RS_ROW;
        end else if (w_line_wrap) begin
            w_vsub_nxt = '0;
            w_row_nxt  = '0;
            if (w_vwin_nxt && (w_v_nxt != Y_LO)) begin
                w_row_nxt = r_row;
                if (r_vsub == SUB_LAST) begin
                    w_row_nxt = r_row + RW'(1);
                end else begin
                    w_vsub_nxt = r_vsub + SW'(1);
                end
            end
        end
    end

    // Raw (polarity-free) control bits for the next position.
    always_comb begin
        w_ctl0.hs  = (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END);
        w_ctl0.vs  = (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END);
        w_ctl0.de  = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
        w_ctl0.win = w_hwin_nxt && w_vwin_nxt;
        w_ctl0.ls  = (w_h_nxt == '0) && (w_v_nxt < V_ACT);
        w_ctl0.fs  = (w_h_nxt == '0) && (w_v_nxt == '0);
    end

    // Position and address counters plus the resync edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= 1'b0;
            r_fs_prev <= 1'b1;
            r_h       <= '0;
            r_v       <= '0;
            r_hsub    <= '0;
            r_vsub    <= '0;
            r_col     <= '0;
            r_row     <= '0;
        end else begin
            r_run     <= 1'b1;
            r_fs_prev <= frame_sync;
            r_h       <= w_h_nxt;
            r_v       <= w_v_nxt;
            r_hsub    <= w_hsub_nxt;
            r_vsub    <= w_vsub_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
        end
    end

    // Stage 0 read request and the RD_LAT-deep control delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en  <= 1'b0;
            rd_row <= '0;
            rd_col <= '0;
            for (int unsigned k = 0; k < RD_LAT + 1; k++) begin
                r_ctl[k] <= '0;
            end
        end else begin
            rd_en    <= w_ctl0.win;
            rd_row   <= w_row_nxt;
            rd_col   <= w_col_nxt;
            r_ctl[0] <= w_ctl0;
            for (int unsigned k = 1; k < RD_LAT + 1; k++) begin
                r_ctl[k] <= r_ctl[k-1];
            end
        end
    end

    // Output stage: merge returned pixel, border and blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            rgb         <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= r_ctl[RD_LAT].hs ? HS_ON : ~HS_ON;
            vsync       <= r_ctl[RD_LAT].vs ? VS_ON : ~VS_ON;
            de          <= r_ctl[RD_LAT].de;
            rgb         <= r_ctl[RD_LAT].win ? pix_rgb :
                           (r_ctl[RD_LAT].de ? border_rgb : '0);
            line_start  <= r_ctl[RD_LAT].ls;
            frame_start <= r_ctl[RD_LAT].fs;
        end
    end

endmodule

// File: tb/tb_vga_scaled_timing_gen.sv
// Bench for vga_scaled_timing_gen: two small instances (SCALE=2/RD_LAT=1 and
// SCALE=1/RD_LAT=3) sharing a 23x12 raster; expected outputs are derived from
// a bench-side position tracker and closed-form window arithmetic.
module tb_vga_scaled_timing_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fs_a, fs_b;
    logic [11:0] border = 12'hABC;
    logic [11:0] pix_a, pix_b, pb1, pb2;

    logic        rd_en_a, hs_a, vs_a, de_a, ls_a, fst_a;
    logic [0:0]  rd_row_a;
    logic [1:0]  rd_col_a;
    logic [11:0] rgb_a;
    logic        rd_en_b, hs_b, vs_b, de_b, ls_b, fst_b;
    logic [0:0]  rd_row_b;
    logic [1:0]  rd_col_b;
    logic [11:0] rgb_b;

    int n_tests = 0;
    int n_fail  = 0;

    int ha, va, hb, vb;
    bit started, pfa, pfb;
    int qha[$], qva[$], qhb[$], qvb[$];

    always #5 clk = ~clk;

    vga_scaled_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .SRC_W(4), .SRC_H(2),
        .SCALE(2), .RD_LAT(1), .RESYNC_LINE(4)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_sync(fs_a), .border_rgb(border),
        .pix_rgb(pix_a), .rd_en(rd_en_a), .rd_row(rd_row_a), .rd_col(rd_col_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb(rgb_a),
        .line_start(ls_a), .frame_start(fst_a)
    );

    vga_scaled_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .SRC_W(4), .SRC_H(2),
        .SCALE(1), .RD_LAT(3), .RESYNC_LINE(4)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_sync(fs_b), .border_rgb(border),
        .pix_rgb(pix_b), .rd_en(rd_en_b), .rd_row(rd_row_b), .rd_col(rd_col_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b),
        .line_start(ls_b), .frame_start(fst_b)
    );

    // Buffer models: echo {row,col} after RD_LAT cycles.
    always @(posedge clk) begin
        pix_a <= {9'b0, rd_row_a, rd_col_a};
        pb1   <= {9'b0, rd_row_b, rd_col_b};
        pb2   <= pb1;
        pix_b <= pb2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_rgb(int h, int v, int x0, int y0, int sc);
        if (h >= 16 || v >= 8) return 12'h000;
        if (h >= x0 && h < x0 + 4*sc && v >= y0 && v < y0 + 2*sc)
            return 12'((v - y0) / sc * 4 + (h - x0) / sc);
        return 12'hABC;
    endfunction

    task automatic check_one(input string nm, input int x0, input int y0, input int sc,
                             input int nh, input int nv, input bit ho, input int oh, input int ov,
                             input logic en, input logic [0:0] row, input logic [1:0] col,
                             input logic hs, input logic vs, input logic d,
                             input logic [11:0] c, input logic ls, input logic fst);
        bit w;
        w = nh >= x0 && nh < x0 + 4*sc && nv >= y0 && nv < y0 + 2*sc;
        chk($sformatf("%s.rd_en@(%0d,%0d)", nm, nh, nv), en, w);
        if (w) begin
            chk($sformatf("%s.rd_row@(%0d,%0d)", nm, nh, nv), row, (nv - y0) / sc);
            chk($sformatf("%s.rd_col@(%0d,%0d)", nm, nh, nv), col, (nh - x0) / sc);
        end
        if (ho) begin
            chk($sformatf("%s.hsync@(%0d,%0d)", nm, oh, ov), hs, oh >= 18 && oh <= 20);
            chk($sformatf("%s.vsync@(%0d,%0d)", nm, oh, ov), vs, ov >= 9 && ov <= 10);
            chk($sformatf("%s.de@(%0d,%0d)", nm, oh, ov), d, oh < 16 && ov < 8);
            chk($sformatf("%s.rgb@(%0d,%0d)", nm, oh, ov), c, exp_rgb(oh, ov, x0, y0, sc));
            chk($sformatf("%s.line_start@(%0d,%0d)", nm, oh, ov), ls, oh == 0 && ov < 8);
            chk($sformatf("%s.frame_start@(%0d,%0d)", nm, oh, ov), fst, oh == 0 && ov == 0);
        end else begin
            chk($sformatf("%s.hsync_fill", nm), hs, 0);
            chk($sformatf("%s.vsync_fill", nm), vs, 0);
            chk($sformatf("%s.de_fill", nm), d, 0);
            chk($sformatf("%s.rgb_fill", nm), c, 0);
            chk($sformatf("%s.line_start_fill", nm), ls, 0);
            chk($sformatf("%s.frame_start_fill", nm), fst, 0);
        end
    endtask

    function automatic void advance(inout int h, inout int v, input bit edge_seen);
        if (!started) begin
            h = 0; v = 0;
        end else if (edge_seen) begin
            h = 0; v = 4;
        end else if (h == 22) begin
            h = 0;
            v = (v == 11) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endfunction

    task automatic step();
        int n;
        @(posedge clk);
        advance(ha, va, fs_a && !pfa);
        advance(hb, vb, fs_b && !pfb);
        started = 1'b1;
        pfa = fs_a;
        pfb = fs_b;
        if (qha.size() >= 8) begin
            void'(qha.pop_front()); void'(qva.pop_front());
            void'(qhb.pop_front()); void'(qvb.pop_front());
        end
        qha.push_back(ha); qva.push_back(va);
        qhb.push_back(hb); qvb.push_back(vb);
        @(negedge clk);
        n = qha.size();
        if (n > 2)
            check_one("A", 4, 2, 2, ha, va, 1'b1, qha[n-3], qva[n-3], rd_en_a, rd_row_a,
                      rd_col_a, hs_a, vs_a, de_a, rgb_a, ls_a, fst_a);
        else
            check_one("A", 4, 2, 2, ha, va, 1'b0, 0, 0, rd_en_a, rd_row_a,
                      rd_col_a, hs_a, vs_a, de_a, rgb_a, ls_a, fst_a);
        if (n > 4)
            check_one("B", 6, 3, 1, hb, vb, 1'b1, qhb[n-5], qvb[n-5], rd_en_b, rd_row_b,
                      rd_col_b, hs_b, vs_b, de_b, rgb_b, ls_b, fst_b);
        else
            check_one("B", 6, 3, 1, hb, vb, 1'b0, 0, 0, rd_en_b, rd_row_b,
                      rd_col_b, hs_b, vs_b, de_b, rgb_b, ls_b, fst_b);
    endtask

    task automatic run_to(input int th, input int tv, input string tag);
        int n = 0;
        while (!(ha == th && va == tv) && n < 600) begin
            step();
            n++;
        end
        chk(tag, (ha == th && va == tv), 1);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, ".hsync"}, hs_a, 0);
        chk({nm, ".vsync"}, vs_a, 0);
        chk({nm, ".de"}, de_a, 0);
        chk({nm, ".rgb"}, rgb_a, 0);
        chk({nm, ".rd_en"}, rd_en_a, 0);
        chk({nm, ".rd_row"}, rd_row_a, 0);
        chk({nm, ".rd_col"}, rd_col_a, 0);
        chk({nm, ".line_start"}, ls_a, 0);
        chk({nm, ".frame_start"}, fst_a, 0);
        chk({nm, ".b_hsync"}, hs_b, 0);
        chk({nm, ".b_de"}, de_b, 0);
        chk({nm, ".b_rgb"}, rgb_b, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        started = 1'b0;
        pfa = 1'b1;
        pfb = 1'b1;
        qha.delete(); qva.delete(); qhb.delete(); qvb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fa_at, fb_at;
        rst_n = 1'b0;
        fs_a  = 1'b0;
        fs_b  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        release_reset();

        // Two full frames from reset.
        repeat (552) step();

        // Rising edge of frame_sync at (7,3) jumps to (0,4), row 1.
        run_to(7, 3, "reach_7_3");
        fs_a = 1'b1;
        step();
        chk("resync.h", ha, 0);
        chk("resync.rd_row", rd_row_a, 1);
        chk("resync.rd_col", rd_col_a, 0);
        chk("resync.rd_en", rd_en_a, 0);
        // Held high: no further resync across a frame wrap.
        repeat (300) step();
        fs_a = 1'b0;
        repeat (5) step();

        // Edge coincident with the frame wrap: resync wins, no frame_start.
        run_to(22, 11, "reach_22_11");
        fs_a = 1'b1;
        step();
        fs_a = 1'b0;
        step();
        step();
        chk("wrap_resync.frame_start", fst_a, 0);
        chk("wrap_resync.line_start", ls_a, 1);
        repeat (40) step();

        // Asynchronous reset mid active line, frame_sync held high through release.
        run_to(5, 3, "reach_5_3");
        fs_a = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async");
        repeat (2) @(negedge clk);
        release_reset();
        fa_at = 0;
        fb_at = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (fst_a === 1'b1 && fa_at == 0) fa_at = k;
            if (fst_b === 1'b1 && fb_at == 0) fb_at = k;
        end
        chk("rst_fs_latency_a", fa_at, 3);
        chk("rst_fs_latency_b", fb_at, 5);
        repeat (300) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
